// File: rtl/music_wave_pkg.sv
// Shared types and helpers for the multi-waveform tone generator voices.
package music_wave_pkg;

   typedef enum logic [1:0] {
      TRI    = 2'd0,
      SQUARE = 2'd1,
      SAW    = 2'd2,
      SINE   = 2'd3
   } wave_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DEFAULT_SAMPLE_RATE = 32000;
   localparam int DEFAULT_MAX_FREQ    = 8000;

   // Rounded raw*amp/full_scale; callers pass a constant full_scale so the divide folds away.
   function automatic logic [31:0] scale(input logic [31:0] raw,
                                         input logic [31:0] amp,
                                         input logic [31:0] full_scale);
      logic [31:0] prod;
      prod = raw * amp + (full_scale >> 1);
      return prod / full_scale;
   endfunction

endpackage

// File: rtl/wave_sine_rom.sv
// Combinational sine lookup built from a quarter-wave table.
// The table is script-generated for SAMPLE_W=8, TABLE_AW=7: round(127.5*(1+sin(2*pi*i/128))).
module wave_sine_rom #(
   parameter int SAMPLE_W = 8,
   parameter int TABLE_AW = 7
) (
   input  logic [TABLE_AW-1:0] index,
   output logic [SAMPLE_W-1:0] value
);

   localparam int Q = 1 << (TABLE_AW - 2);

   localparam logic [7:0] QUARTER [0:32] = '{
      8'd128, 8'd134, 8'd140, 8'd146, 8'd152, 8'd158, 8'd165, 8'd170,
      8'd176, 8'd182, 8'd188, 8'd193, 8'd198, 8'd203, 8'd208, 8'd213,
      8'd218, 8'd222, 8'd226, 8'd230, 8'd234, 8'd237, 8'd240, 8'd243,
      8'd245, 8'd248, 8'd250, 8'd251, 8'd253, 8'd254, 8'd254, 8'd255,
      8'd255
   };

   logic [TABLE_AW-2:0] half_pos;
   logic [TABLE_AW-2:0] k;

   // Second quarter mirrors the first; the negative half is the complement,
   // except its midpoint, which the generator rounded up to the same value as entry 0.
   always_comb begin
      half_pos = index[TABLE_AW-2:0];
      k        = (32'(half_pos) > Q) ? -half_pos : half_pos;
      if (!index[TABLE_AW-1]) begin
         value = SAMPLE_W'(QUARTER[k]);
      end else if (half_pos == '0) begin
         value = SAMPLE_W'(QUARTER[0]);
      end else begin
         value = SAMPLE_W'(8'd255 - QUARTER[k]);
      end
   end

endmodule

// File: rtl/signal_generator_multiwave.sv
// Per-voice tone generator: phase accumulator, shape select, smoothed amplitude,
// and click-free start/stop/shape change feeding the mixer.
module signal_generator_multiwave
   import music_wave_pkg::*;
#(
   parameter int SAMPLE_W    = 8,
   parameter int TABLE_AW    = 7,
   parameter int FREQ_W      = 14,
   parameter int SAMPLE_RATE = DEFAULT_SAMPLE_RATE,
   parameter int MAX_FREQ    = DEFAULT_MAX_FREQ,
   parameter int RAMP_DIV    = 100
) (
   input  logic                CLK_32KHz,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [FREQ_W-1:0]   inputFrequency,
   input  logic [1:0]          waveSelect,
   input  logic [SAMPLE_W-1:0] inputAmplitude,
   input  logic [TABLE_AW-1:0] phaseOffset,
   output logic [SAMPLE_W-1:0] outputSample,
   output logic                indexZero,
   output logic                busy,
   output logic [1:0]          activeMode
);

   localparam int D     = 1 << TABLE_AW;
   localparam int M     = (1 << SAMPLE_W) - 1;
   localparam int CNT_W = $clog2(SAMPLE_RATE + (1 << FREQ_W));
   localparam int DIV_W = $clog2(RAMP_DIV + 2);

   localparam logic [CNT_W-1:0]          RATE      = CNT_W'(SAMPLE_RATE);
   localparam logic [CNT_W+TABLE_AW-1:0] RATE_WIDE = (CNT_W + TABLE_AW)'(SAMPLE_RATE);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_RUN   = RUN;
   localparam logic [1:0] ST_DRAIN = DRAIN;

   logic [1:0]          state;
   logic [1:0]          state_next;
   logic [CNT_W-1:0]    counter;
   logic [CNT_W-1:0]    freq_clamped;
   logic [CNT_W-1:0]    acc_sum;
   logic [CNT_W-1:0]    phase_load;
   logic                wrap;
   logic [TABLE_AW-1:0] idx;
   logic [31:0]         tri_value;
   logic [SAMPLE_W-1:0] raw;
   logic [SAMPLE_W-1:0] sine_value;
   logic [SAMPLE_W-1:0] scaled_sample;
   logic [SAMPLE_W-1:0] smooth_amp;
   logic [SAMPLE_W-1:0] amp_target;
   logic [DIV_W-1:0]    ramp_div;

   assign freq_clamped = (32'(inputFrequency) > 32'(MAX_FREQ)) ? CNT_W'(MAX_FREQ)
                                                               : CNT_W'(inputFrequency);
   assign acc_sum      = counter + freq_clamped;
   assign wrap         = (state != ST_IDLE) && (acc_sum >= RATE);
   assign idx          = TABLE_AW'({counter, {TABLE_AW{1'b0}}} / RATE_WIDE);
   assign phase_load   = CNT_W'((32'(phaseOffset) * 32'(SAMPLE_RATE)) / 32'(D));

   assign tri_value = (32'(idx) <= 32'(D / 2))
                      ? ((32'(idx) << (SAMPLE_W + 1)) / 32'(D))
                      : (((32'(D) - 32'(idx)) << (SAMPLE_W + 1)) / 32'(D));

   wave_sine_rom #(
      .SAMPLE_W (SAMPLE_W),
      .TABLE_AW (TABLE_AW)
   ) u_sine_rom (
      .index (idx),
      .value (sine_value)
   );

   always_comb begin
      raw = '0;
      case (activeMode)
         TRI:     raw = (tri_value > 32'(M)) ? SAMPLE_W'(M) : SAMPLE_W'(tri_value);
         SQUARE:  raw = (32'(idx) < 32'(D / 2)) ? SAMPLE_W'(M) : '0;
         SAW:     raw = SAMPLE_W'((32'(idx) << SAMPLE_W) / 32'(D));
         default: raw = sine_value;
      endcase
   end

   assign scaled_sample = SAMPLE_W'(scale(32'(raw), 32'(smooth_amp), 32'(M)));
   assign amp_target    = (state == ST_RUN) ? inputAmplitude : '0;
   assign busy          = (state != ST_IDLE);

   // A renewed play request during DRAIN resumes without reloading the phase.
   always_comb begin
      state_next = ST_IDLE;
      case (state)
         ST_IDLE:  state_next = enable ? ST_RUN : ST_IDLE;
         ST_RUN:   state_next = enable ? ST_RUN : ST_DRAIN;
         ST_DRAIN: begin
            if (enable) begin
               state_next = ST_RUN;
            end else if (smooth_amp == '0) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_DRAIN;
            end
         end
         default:  state_next = ST_IDLE;
      endcase
   end

   // Amplitude glides one LSB per divider period toward the target, so
   // start, stop and amplitude changes never step the output.
   always_ff @(posedge CLK_32KHz or negedge reset_n) begin
      if (!reset_n) begin
         ramp_div   <= '0;
         smooth_amp <= '0;
      end else if (ramp_div == DIV_W'(RAMP_DIV)) begin
         ramp_div <= '0;
         if (smooth_amp < amp_target) begin
            smooth_amp <= smooth_amp + 1'b1;
         end else if (smooth_amp > amp_target) begin
            smooth_amp <= smooth_amp - 1'b1;
         end
      end else begin
         ramp_div <= ramp_div + 1'b1;
      end
   end

   // Shape changes land only on a wrap so each new shape starts at index 0.
   always_ff @(posedge CLK_32KHz or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         counter      <= '0;
         outputSample <= '0;
         indexZero    <= 1'b0;
         activeMode   <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE) begin
            counter      <= enable ? phase_load : '0;
            outputSample <= '0;
            indexZero    <= 1'b0;
            activeMode   <= waveSelect;
         end else begin
            counter      <= wrap ? (acc_sum - RATE) : acc_sum;
            outputSample <= scaled_sample;
            indexZero    <= wrap;
            if (wrap) begin
               activeMode <= waveSelect;
            end
         end
      end
   end

endmodule

// File: tb/tb_signal_generator_multiwave.sv
// Self-checking bench for signal_generator_multiwave: directed scenarios plus random
// segments, compared each cycle against an arithmetic model of the generator.
module tb_signal_generator_multiwave;

   localparam int  SAMPLE_W = 8;
   localparam int  TABLE_AW = 7;
   localparam int  FREQ_W   = 14;
   localparam int  SR       = 32000;
   localparam int  MAXF     = 8000;
   localparam int  RDIV     = 100;
   localparam int  D        = 128;
   localparam int  M        = 255;
   localparam real PI       = 3.14159265358979;

   logic                CLK_32KHz;
   logic                reset_n;
   logic                enable;
   logic [FREQ_W-1:0]   inputFrequency;
   logic [1:0]          waveSelect;
   logic [SAMPLE_W-1:0] inputAmplitude;
   logic [TABLE_AW-1:0] phaseOffset;
   logic [SAMPLE_W-1:0] outputSample;
   logic                indexZero;
   logic                busy;
   logic [1:0]          activeMode;

   int total;
   int bad;

   int m_state;
   int m_cnt;
   int m_amp;
   int m_div;
   int m_mode;
   int m_out;
   int m_iz;

   signal_generator_multiwave #(
      .SAMPLE_W    (SAMPLE_W),
      .TABLE_AW    (TABLE_AW),
      .FREQ_W      (FREQ_W),
      .SAMPLE_RATE (SR),
      .MAX_FREQ    (MAXF),
      .RAMP_DIV    (RDIV)
   ) dut (
      .CLK_32KHz      (CLK_32KHz),
      .reset_n        (reset_n),
      .enable         (enable),
      .inputFrequency (inputFrequency),
      .waveSelect     (waveSelect),
      .inputAmplitude (inputAmplitude),
      .phaseOffset    (phaseOffset),
      .outputSample   (outputSample),
      .indexZero      (indexZero),
      .busy           (busy),
      .activeMode     (activeMode)
   );

   initial CLK_32KHz = 1'b0;
   always #5 CLK_32KHz = ~CLK_32KHz;

   function automatic int shapeValue(input int mode, input int i);
      int v;
      case (mode)
         0: begin
            v = (i <= D / 2) ? i * 2 * (M + 1) / D : (D - i) * 2 * (M + 1) / D;
            if (v > M) v = M;
         end
         1:       v = (i < D / 2) ? M : 0;
         2:       v = i * (M + 1) / D;
         default: v = int'($floor(M / 2.0 * (1.0 + $sin(2.0 * PI * i / D)) + 0.5));
      endcase
      return v;
   endfunction

   task automatic modelReset();
      m_state = 0;
      m_cnt   = 0;
      m_amp   = 0;
      m_div   = 0;
      m_mode  = 0;
      m_out   = 0;
      m_iz    = 0;
   endtask

   // One sample period of the generator, using the inputs present at the edge.
   task automatic modelTick();
      int f;
      int tgt;
      int n_state;
      int n_amp;
      bit wrapped;
      f     = (int'(inputFrequency) > MAXF) ? MAXF : int'(inputFrequency);
      tgt   = (m_state == 1) ? int'(inputAmplitude) : 0;
      n_amp = m_amp;
      if (m_div == RDIV) begin
         m_div = 0;
         if (tgt > m_amp) n_amp = m_amp + 1;
         else if (tgt < m_amp) n_amp = m_amp - 1;
      end else begin
         m_div = m_div + 1;
      end
      case (m_state)
         0:       n_state = enable ? 1 : 0;
         1:       n_state = enable ? 1 : 2;
         default: n_state = enable ? 1 : ((m_amp == 0) ? 0 : 2);
      endcase
      if (m_state == 0) begin
         m_out  = 0;
         m_iz   = 0;
         m_mode = int'(waveSelect);
         m_cnt  = enable ? int'(phaseOffset) * SR / D : 0;
      end else begin
         m_out   = (shapeValue(m_mode, m_cnt * D / SR) * m_amp + M / 2) / M;
         wrapped = (m_cnt + f) >= SR;
         m_iz    = wrapped ? 1 : 0;
         if (wrapped) m_mode = int'(waveSelect);
         m_cnt = (m_cnt + f) % SR;
      end
      m_state = n_state;
      m_amp   = n_amp;
   endtask

   task automatic checkOutput(input string tag);
      total++;
      assert (outputSample === SAMPLE_W'(m_out)) else begin
         bad++;
         $error("[TB] FAIL %s outputSample observed=%0d expected=%0d", tag, outputSample, m_out);
      end
      total++;
      assert (indexZero === 1'(m_iz)) else begin
         bad++;
         $error("[TB] FAIL %s indexZero observed=%0b expected=%0d", tag, indexZero, m_iz);
      end
      total++;
      assert (busy === (m_state != 0)) else begin
         bad++;
         $error("[TB] FAIL %s busy observed=%0b expected=%0b", tag, busy, (m_state != 0));
      end
      total++;
      assert (activeMode === 2'(m_mode)) else begin
         bad++;
         $error("[TB] FAIL %s activeMode observed=%0d expected=%0d", tag, activeMode, m_mode);
      end
   endtask

   task automatic applyStimulus(input bit en, input int freq, input int ws,
                                input int amp, input int ph);
      enable         = en;
      inputFrequency = FREQ_W'(freq);
      waveSelect     = 2'(ws);
      inputAmplitude = SAMPLE_W'(amp);
      phaseOffset    = TABLE_AW'(ph);
   endtask

   task automatic step(input string tag);
      @(posedge CLK_32KHz);
      modelTick();
      #1;
      checkOutput(tag);
   endtask

   // Cycles between two consecutive indexZero pulses.
   task automatic measurePeriod(input string tag, input int expected);
      int gap;
      for (int n = 0; n < 400 && indexZero !== 1'b1; n++) step(tag);
      gap = 0;
      do begin
         step(tag);
         gap++;
      end while (indexZero !== 1'b1 && gap < 400);
      total++;
      assert (gap == expected) else begin
         bad++;
         $error("[TB] FAIL %s period observed=%0d expected=%0d", tag, gap, expected);
      end
   endtask

   initial begin
      int waited;
      int pulses;
      total   = 0;
      bad     = 0;
      reset_n = 1'b0;
      applyStimulus(0, 1000, 0, 255, 0);
      modelReset();
      #12;
      checkOutput("reset");
      @(negedge CLK_32KHz);
      reset_n = 1'b1;
      repeat (3) step("idle");

      $display("[TB] triangle ramp to full amplitude");
      applyStimulus(1, 1000, 0, 255, 0);
      repeat (26000) step("tri_ramp");
      measurePeriod("tri_period", 32);

      $display("[TB] shape switch on wrap");
      for (int n = 0; n < 64 && m_cnt != 10000; n++) step("tri_seek");
      applyStimulus(1, 1000, 2, 255, 0);
      repeat (21) step("switch_hold");
      total++;
      assert (activeMode === 2'd0) else begin
         bad++;
         $error("[TB] FAIL switch_before_wrap activeMode observed=%0d expected=0", activeMode);
      end
      step("switch_wrap");
      total++;
      assert (activeMode === 2'd2 && indexZero === 1'b1) else begin
         bad++;
         $error("[TB] FAIL switch_at_wrap mode/iz observed=%0d/%0b expected=2/1", activeMode, indexZero);
      end
      repeat (40) step("saw");

      $display("[TB] square at 500 Hz");
      applyStimulus(1, 500, 1, 255, 0);
      repeat (100) step("square");
      measurePeriod("sq_period", 64);

      $display("[TB] random segments");
      for (int seg = 0; seg < 16; seg++) begin
         int freq;
         freq = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 16383));
         applyStimulus($urandom_range(0, 3) != 0, freq, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
         repeat ($urandom_range(30, 300)) step("random");
      end

      $display("[TB] asynchronous reset while playing");
      applyStimulus(1, 1000, 3, 255, 0);
      for (int n = 0; n < 2000 && m_out == 0; n++) step("pre_reset");
      reset_n = 1'b0;
      #1;
      modelReset();
      checkOutput("async_reset");
      #1;
      reset_n = 1'b1;
      applyStimulus(0, 1000, 3, 0, 0);
      repeat (20) step("post_reset_idle");

      $display("[TB] drain from amplitude 10");
      applyStimulus(1, 1000, 3, 10, 0);
      repeat (1160) step("amp_to_10");
      applyStimulus(0, 1000, 3, 10, 0);
      waited = 0;
      while (busy === 1'b1 && waited < 1111) begin
         step("drain");
         waited++;
      end
      total++;
      assert (busy === 1'b0 && outputSample === '0 && waited <= 1111) else begin
         bad++;
         $error("[TB] FAIL drain_end busy/out/cycles observed=%0b/%0d/%0d expected=0/0/<=1111",
                busy, outputSample, waited);
      end

      $display("[TB] frequency clamp and start phase");
      applyStimulus(1, 12000, 0, 10, 32);
      step("clamp_start");
      repeat (2) begin
         step("clamp_pre");
         total++;
         assert (indexZero === 1'b0) else begin
            bad++;
            $error("[TB] FAIL clamp_pre indexZero observed=%0b expected=0", indexZero);
         end
      end
      step("clamp_wrap");
      total++;
      assert (indexZero === 1'b1) else begin
         bad++;
         $error("[TB] FAIL clamp_first_wrap indexZero observed=%0b expected=1", indexZero);
      end
      measurePeriod("clamp_period", 4);

      $display("[TB] zero frequency holds");
      applyStimulus(1, 0, 0, 10, 32);
      step("f0_settle");
      pulses = 0;
      repeat (50) begin
         step("f0");
         if (indexZero === 1'b1) pulses++;
      end
      total++;
      assert (pulses == 0) else begin
         bad++;
         $error("[TB] FAIL f0_no_wrap pulses observed=%0d expected=0", pulses);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
